// File: rtl/dma_fifo_pkg.sv
// rtl/dma_fifo_pkg.sv - shared DMA FIFO defaults and clog2 helper
package dma_fifo_pkg;

    localparam int DMA_FIFO_DATA_WIDTH = 32;
    localparam int DMA_FIFO_DEPTH      = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_fifo_param_if.sv
// rtl/dma_fifo_param_if.sv - DMA FIFO request/status bundle
interface dma_fifo_param_if
    import dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_FIFO_DATA_WIDTH,
    parameter int DEPTH      = DMA_FIFO_DEPTH
);
    localparam int AW = clog2(DEPTH);

    logic                  FlushFIFO;
    logic [DATA_WIDTH-1:0] in_HRDATA_m;
    logic                  WriteDataEnable;
    logic                  ReadDataEnable;
    logic [DATA_WIDTH-1:0] out_HWDATA_m;
    logic                  ReadValid;
    logic                  empty;
    logic                  full;
    logic                  AlmostFull;
    logic                  AlmostEmpty;
    logic [AW:0]           level;
    logic                  Overflow;
    logic                  Underflow;

    modport master (
        output FlushFIFO, in_HRDATA_m, WriteDataEnable, ReadDataEnable,
        input  out_HWDATA_m, ReadValid, empty, full, AlmostFull, AlmostEmpty,
               level, Overflow, Underflow
    );

    modport slave (
        input  FlushFIFO, in_HRDATA_m, WriteDataEnable, ReadDataEnable,
        output out_HWDATA_m, ReadValid, empty, full, AlmostFull, AlmostEmpty,
               level, Overflow, Underflow
    );

endinterface

// File: rtl/dma_fifo_mem.sv
// rtl/dma_fifo_mem.sv - FIFO storage, one write port and one async read port
module dma_fifo_mem
    import dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_FIFO_DATA_WIDTH,
    parameter int DEPTH      = DMA_FIFO_DEPTH,
    parameter int AW         = clog2(DEPTH)
)(
    input  logic                  HCLK,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Storage is deliberately left unreset; only the pointers define validity.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_fifo_param.sv
// rtl/dma_fifo_param.sv - parametrised DMA data FIFO with flags, flush and FWFT option
module dma_fifo_param
    import dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_FIFO_DATA_WIDTH,
    parameter int DEPTH      = DMA_FIFO_DEPTH,
    parameter bit FWFT       = 1'b0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
)(
    input logic             HCLK,
    input logic             FIFOReset,
    dma_fifo_param_if.slave fifo
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]         wp, rp;
    logic [AW:0]           count;
    logic                  ovf, unf;
    logic                  wr_ok, rd_ok;
    logic                  is_empty, is_full;
    logic [DATA_WIDTH-1:0] head;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_COUNT);

    // Flush masks both requests so nothing is stored or popped that cycle.
    assign wr_ok = fifo.WriteDataEnable && !is_full  && !fifo.FlushFIFO;
    assign rd_ok = fifo.ReadDataEnable  && !is_empty && !fifo.FlushFIFO;

    dma_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .HCLK  (HCLK),
        .we    (wr_ok),
        .waddr (wp),
        .wdata (fifo.in_HRDATA_m),
        .raddr (rp),
        .rdata (head)
    );

    always_ff @(posedge HCLK or posedge FIFOReset) begin
        if (FIFOReset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (fifo.FlushFIFO) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural rollover.
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fifo.WriteDataEnable && is_full)  ovf <= 1'b1;
            if (fifo.ReadDataEnable  && is_empty) unf <= 1'b1;
        end
    end

    assign fifo.empty       = is_empty;
    assign fifo.full        = is_full;
    assign fifo.AlmostFull  = (int'(count) >= AF_LEVEL);
    assign fifo.AlmostEmpty = (int'(count) <= AE_LEVEL);
    assign fifo.level       = count;
    assign fifo.Overflow    = ovf;
    assign fifo.Underflow   = unf;

    if (FWFT) begin : g_fwft
        assign fifo.out_HWDATA_m = head;
        assign fifo.ReadValid    = !is_empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout;
        logic                  rvalid;

        always_ff @(posedge HCLK or posedge FIFOReset) begin
            if (FIFOReset) begin
                dout   <= '0;
                rvalid <= 1'b0;
            end else begin
                rvalid <= rd_ok;
                if (rd_ok) dout <= head;
            end
        end

        assign fifo.out_HWDATA_m = dout;
        assign fifo.ReadValid    = rvalid;
    end

endmodule

// File: tb/tb_dma_fifo_param.sv
// tb/tb_dma_fifo_param.sv - scoreboard bench for registered and FWFT FIFO builds
module tb_dma_fifo_param;
    import dma_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic HCLK = 1'b0;
    logic FIFOReset;
    always #5 HCLK = ~HCLK;

    dma_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if0 ();
    dma_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if1 ();

    dma_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0),
                     .AF_LEVEL(AF), .AE_LEVEL(AE))
        dut0 (.HCLK(HCLK), .FIFOReset(FIFOReset), .fifo(if0));

    dma_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1),
                     .AF_LEVEL(AF), .AE_LEVEL(AE))
        dut1 (.HCLK(HCLK), .FIFOReset(FIFOReset), .fifo(if1));

    logic [31:0] mq   [$];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    bit          m_ovf, m_unf, prev_rd;
    logic [31:0] last_out0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        prev_rd = 1'b0;
    endtask

    task automatic check_state();
        int lvl;
        lvl = mq.size();
        chk("level0",   32'(if0.level),       32'(lvl));
        chk("level1",   32'(if1.level),       32'(lvl));
        chk("empty0",   32'(if0.empty),       32'(lvl == 0));
        chk("full0",    32'(if0.full),        32'(lvl == DEPTH));
        chk("afull0",   32'(if0.AlmostFull),  32'(lvl >= AF));
        chk("aempty0",  32'(if0.AlmostEmpty), 32'(lvl <= AE));
        chk("ovf0",     32'(if0.Overflow),    32'(m_ovf));
        chk("unf0",     32'(if0.Underflow),   32'(m_unf));
        chk("full1",    32'(if1.full),        32'(lvl == DEPTH));
        chk("ovf1",     32'(if1.Overflow),    32'(m_ovf));
        chk("unf1",     32'(if1.Underflow),   32'(m_unf));
        chk("rvalid0",  32'(if0.ReadValid),   32'(prev_rd));
        chk("dout0",    if0.out_HWDATA_m,     last_out0);
        chk("rvalid1",  32'(if1.ReadValid),   32'(lvl != 0));
        if (lvl != 0) chk("head1", if1.out_HWDATA_m, mq[0]);
    endtask

    task automatic cycle(input bit wr, input bit rd, input logic [31:0] d, input bit fl);
        bit wok, rok;
        @(negedge HCLK);
        check_state();
        if0.WriteDataEnable = wr; if1.WriteDataEnable = wr;
        if0.ReadDataEnable  = rd; if1.ReadDataEnable  = rd;
        if0.in_HRDATA_m     = d;  if1.in_HRDATA_m     = d;
        if0.FlushFIFO       = fl; if1.FlushFIFO       = fl;
        wok = wr && (mq.size() < DEPTH) && !fl;
        rok = rd && (mq.size() != 0) && !fl;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && mq.size() == DEPTH) m_ovf = 1'b1;
            if (rd && mq.size() == 0)     m_unf = 1'b1;
        end
        if (rok) begin
            last_out0 = mq.pop_front();
            exp0.push_back(last_out0);
            exp1.push_back(last_out0);
        end
        if (wok) mq.push_back(d);
        prev_rd = rok;
    endtask

    // Registered build: every ReadValid pulse must carry the next expected word.
    always @(negedge HCLK) begin
        if (!FIFOReset && if0.ReadValid) begin
            if (exp0.size() == 0) chk("spurious_rvalid0", 32'd1, 32'd0);
            else                  chk("pop0", if0.out_HWDATA_m, exp0.pop_front());
        end
    end

    // FWFT build: the word presented while a pop is acknowledged is the one consumed.
    always @(negedge HCLK) begin
        #2;
        if (!FIFOReset && if1.ReadValid && if1.ReadDataEnable && !if1.FlushFIFO) begin
            if (exp1.size() == 0) chk("spurious_pop1", 32'd1, 32'd0);
            else                  chk("pop1", if1.out_HWDATA_m, exp1.pop_front());
        end
    end

    initial begin
        FIFOReset = 1'b1;
        if0.WriteDataEnable = 0; if1.WriteDataEnable = 0;
        if0.ReadDataEnable  = 0; if1.ReadDataEnable  = 0;
        if0.FlushFIFO       = 0; if1.FlushFIFO       = 0;
        if0.in_HRDATA_m     = '0; if1.in_HRDATA_m    = '0;
        model_clear();
        last_out0 = '0;
        repeat (2) @(posedge HCLK);
        #1 FIFOReset = 1'b0;

        cycle(0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) cycle(1, 0, 32'(i), 0);
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        for (int i = 0; i < 5; i++) cycle(1, 0, $urandom, 0);
        for (int i = 0; i < 40; i++) cycle(1, 1, $urandom, 0);

        while (mq.size() < DEPTH) cycle(1, 0, $urandom, 0);
        cycle(1, 0, 32'hBAD0_0001, 0);
        cycle(1, 0, 32'hBAD0_0002, 1);
        cycle(0, 0, 0, 0);

        cycle(1, 0, 32'hDEAD_BEEF, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  $urandom, $urandom_range(0, 63) == 0);

        cycle(1, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(1, 0, $urandom, 0);
        cycle(0, 0, 0, 0);
        @(posedge HCLK);
        #3 FIFOReset = 1'b1;
        #1;
        chk("rst_level0",  32'(if0.level),       32'd0);
        chk("rst_empty0",  32'(if0.empty),       32'd1);
        chk("rst_full0",   32'(if0.full),        32'd0);
        chk("rst_aempty0", 32'(if0.AlmostEmpty), 32'd1);
        chk("rst_afull0",  32'(if0.AlmostFull),  32'd0);
        chk("rst_dout0",   if0.out_HWDATA_m,     32'd0);
        chk("rst_rvalid0", 32'(if0.ReadValid),   32'd0);
        chk("rst_rvalid1", 32'(if1.ReadValid),   32'd0);
        chk("rst_level1",  32'(if1.level),       32'd0);
        model_clear();
        exp0.delete();
        exp1.delete();
        last_out0 = '0;
        #1 FIFOReset = 1'b0;

        for (int i = 0; i < 60; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1'b0);
        while (mq.size() != 0) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("drain0", 32'(exp0.size()), 32'd0);
        chk("drain1", 32'(exp1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
